// File: rtl/output_ram_reader_pkg.sv
// Shared types and default geometry for the result-RAM read sequencer.
// The state encoding is shared so that a bench or wrapper can decode it.
package output_ram_reader_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FINISH
    } rd_state_t;

endpackage

// File: rtl/output_ram_reader_fifo2.sv
// Two-entry register FIFO with a registered head; a push is visible at the head one cycle later.
// Backpressure is the caller's job: push while full is never issued by the credit rule upstream.
module fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         head_vld,
    output logic [1:0]   occ
);

    logic [W-1:0] tail_q;
    logic         do_pop;

    assign do_pop = pop && head_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_dat <= '0;
            tail_q   <= '0;
            head_vld <= 1'b0;
            occ      <= 2'd0;
        end else begin
            case ({push, do_pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_dat <= push_dat;
                    end else begin
                        tail_q <= push_dat;
                    end
                    head_vld <= 1'b1;
                    occ      <= occ + 2'd1;
                end
                2'b01: begin
                    head_dat <= tail_q;
                    head_vld <= (occ == 2'd2);
                    occ      <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; only the entry order shifts.
                    if (occ == 2'd2) begin
                        head_dat <= tail_q;
                        tail_q   <= push_dat;
                    end else begin
                        head_dat <= push_dat;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/output_ram_reader.sv
// Drains `count` words from the result RAM onto a valid/ready stream; first word valid 3 cycles after start.
// Reads are throttled by FIFO credit so any out_ready pattern is absorbed without loss; one word/cycle when ready.
module output_ram_reader
    import output_ram_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int               CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    rd_state_t         state;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  start_len;
    logic [ADDR_W-1:0] addr_q;
    logic              pend_q;
    logic              pend_last_q;
    logic [1:0]        occ;
    logic [DATA_W:0]   head_dat;
    logic              head_vld;
    logic              pop;
    logic              issue;
    logic              issue_last;
    logic [2:0]        credit_use;

    assign pop = head_vld && out_ready;

    // Entries held or already committed to the FIFO once this cycle's pop retires.
    // pop implies occ >= 1, so the subtraction cannot underflow.
    assign credit_use = {1'b0, occ} + {2'b00, pend_q} - {2'b00, pop};
    assign issue      = (state == READ) && (rd_ptr < len_q) && (credit_use < 3'd2);
    assign issue_last = issue && (rd_ptr == len_q - ONE_C);
    assign start_len  = (count > DEPTH_C) ? DEPTH_C : count;

    assign ram_rd_en = issue;
    assign ram_addr  = issue ? rd_ptr[ADDR_W-1:0] : addr_q;

    assign out_valid = head_vld;
    assign out_data  = head_dat[DATA_W-1:0];
    assign out_last  = head_vld && head_dat[DATA_W];

    fifo2 #(
        .W(DATA_W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (pend_q),
        .push_dat ({pend_last_q, ram_rdata}),
        .pop      (pop),
        .head_dat (head_dat),
        .head_vld (head_vld),
        .occ      (occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            len_q       <= '0;
            rd_ptr      <= '0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            // The read issued this cycle returns data next cycle, tagged if it is the final address.
            pend_q      <= issue;
            pend_last_q <= issue_last;
            if (issue) begin
                addr_q <= rd_ptr[ADDR_W-1:0];
                rd_ptr <= rd_ptr + ONE_C;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        len_q  <= start_len;
                        rd_ptr <= '0;
                        busy   <= 1'b1;
                        if (start_len == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && head_dat[DATA_W]) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_ram_reader.sv
// Directed bench for output_ram_reader: RAM model preloaded with 0xA000_0000+i,
// drains checked for order, timing, stalls, clamping and mid-drain reset.
module tb_output_ram_reader;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    logic [DATA_W-1:0] mem [8];
    int n_checks;
    int n_errors;

    output_ram_reader #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .ram_rd_en (ram_rd_en),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rd_en) begin
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a drain from cycle 0 and follows it until done. mode: 0 ready high,
    // 1 ready toggling 1/0, 2 ready low in cycles 3..6. exp_done 0 skips the timing check.
    task automatic run_drain(input string tag, input int n_req, input int n_exp,
                             input int mode, input int exp_done);
        int idx;
        int issued;
        int max_out;
        int done_cyc;
        bit stall_prev;
        logic [DATA_W-1:0] prev_dat;
        logic [DATA_W-1:0] exp_w;
        idx = 0;
        issued = 0;
        max_out = 0;
        done_cyc = -1;
        stall_prev = 1'b0;
        prev_dat = '0;
        start = 1'b1;
        count = 4'(n_req);
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc < 60 && done_cyc < 0; cyc++) begin
            case (mode)
                1:       out_ready = cyc[0];
                2:       out_ready = !(cyc >= 3 && cyc <= 6);
                default: out_ready = 1'b1;
            endcase
            #1;
            if (cyc == 1) check({tag, " busy"}, 32'(busy), 32'd1);
            if (stall_prev) begin
                check({tag, " hold_vld"}, 32'(out_valid), 32'd1);
                check({tag, " hold_dat"}, out_data, prev_dat);
            end
            if (ram_rd_en) begin
                check({tag, " addr"}, 32'(ram_addr), 32'(issued));
                issued++;
            end
            if (out_valid && out_ready) begin
                exp_w = 32'hA000_0000 + 32'(idx);
                check({tag, " data"}, out_data, exp_w);
                check({tag, " last"}, 32'(out_last), 32'(idx == n_exp - 1));
                idx++;
            end
            if (!out_valid) check({tag, " last_idle"}, 32'(out_last), 32'd0);
            if (issued - idx > max_out) max_out = issued - idx;
            stall_prev = out_valid && !out_ready;
            prev_dat = out_data;
            if (done) done_cyc = cyc;
            tick();
        end
        if (done_cyc < 0) begin
            check({tag, " done_timeout"}, 32'd0, 32'd1);
        end else if (exp_done > 0) begin
            check({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
        end
        check({tag, " words"}, 32'(idx), 32'(n_exp));
        check({tag, " reads"}, 32'(issued), 32'(n_exp));
        check({tag, " outstanding"}, 32'(max_out <= 2), 32'd1);
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 8; i++) mem[i] = 32'hA000_0000 + 32'(i);
        rst = 1'b1;
        start = 1'b0;
        count = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst rd_en", 32'(ram_rd_en), 32'd0);
        check("rst addr", 32'(ram_addr), 32'd0);
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst last", 32'(out_last), 32'd0);
        check("rst data", out_data, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        run_drain("full8", 8, 8, 0, 11);
        tick();
        run_drain("stall3", 3, 3, 2, 10);
        tick();
        run_drain("zero", 0, 0, 0, 1);
        tick();
        run_drain("clamp12", 12, 8, 0, 11);
        tick();
        run_drain("toggle5", 5, 5, 1, 0);
        tick();

        // Reset in cycle 5 of an 8-word drain; the read issued in cycle 5 must be discarded.
        start = 1'b1;
        count = 4'd8;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst busy", 32'(busy), 32'd0);
        check("mid_rst done", 32'(done), 32'd0);
        check("mid_rst rd_en", 32'(ram_rd_en), 32'd0);
        check("mid_rst addr", 32'(ram_addr), 32'd0);
        check("mid_rst valid", 32'(out_valid), 32'd0);
        check("mid_rst last", 32'(out_last), 32'd0);
        check("mid_rst data", out_data, 32'd0);
        tick();
        check("mid_rst discard", 32'(out_valid), 32'd0);
        run_drain("after_rst", 2, 2, 0, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
